// File: rtl/rfg_pkg.sv
// rfg_pkg: FSM state type, Galois LFSR tap masks per supported width, default frequency limits
package rfg_pkg;
  typedef enum logic [1:0] {IDLE, DRAW, COMMIT} state_t;
  localparam int DEF_F_MIN = 300;
  localparam int DEF_F_MAX = 3000;
  localparam logic [31:0] TAPS_12 = 32'h0000_0829;
  localparam logic [31:0] TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] TAPS_20 = 32'h0009_0000;
  localparam logic [31:0] TAPS_24 = 32'h00E1_0000;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;
  function automatic logic [31:0] lfsr_taps(input int w);
    return w == 12 ? TAPS_12 : w == 20 ? TAPS_20 : w == 24 ? TAPS_24 : w == 32 ? TAPS_32 : TAPS_16;
  endfunction
endpackage

// File: rtl/random_freq_bank_if.sv
// random_freq_bank_if: draw request tick in, frequency set and status flags out
interface random_freq_bank_if #(
  parameter int WIDTH = 12,
  parameter int CHANNELS = 2
);
  logic sec;
  logic [CHANNELS*WIDTH-1:0] frequency;
  logic update;
  logic busy;
  logic overrun;
  modport master (output sec, input frequency, update, busy, overrun);
  modport slave (input sec, output frequency, update, busy, overrun);
endinterface

// File: rtl/rfg_lfsr.sv
// rfg_lfsr: maximal-length Galois LFSR stepping every cycle, a zero seed is replaced by 1
module rfg_lfsr
  import rfg_pkg::*;
#(
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  output logic [LFSR_W-1:0] value
);
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [LFSR_W-1:0] INIT = SEED == '0 ? LFSR_W'(1) : SEED;
  // shift right, folding the tap mask in whenever a one drops out of bit 0
  always_ff @(posedge clk)
    value <= rst ? INIT : (value >> 1) ^ (value[0] ? TAPS : '0);
endmodule

// File: rtl/random_freq_bank.sv
// random_freq_bank: per-tick random frequency set, range-checked with clamped fallback; RFG_NO_REPEAT_EN rejects repeats
module random_freq_bank
  import rfg_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CHANNELS = 2,
  parameter int F_MIN = DEF_F_MIN,
  parameter int F_MAX = DEF_F_MAX,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
  parameter int MAX_TRIES = 8
) (
  input logic clk,
  input logic rst,
  random_freq_bank_if.slave bus
);
  localparam int CW = $clog2(CHANNELS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  state_t state;
  logic [LFSR_W-1:0] lfsr;
  logic [CW-1:0] ch;
  logic [TW-1:0] tries;
  logic [CHANNELS*WIDTH-1:0] shadow;
  logic [CHANNELS*WIDTH-1:0] freq;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] clamped;
  logic reject;
  logic accept;
  logic unused_lfsr;
  rfg_lfsr #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (.clk(clk), .rst(rst), .value(lfsr));
  assign unused_lfsr = ^lfsr;
  assign cand = lfsr[WIDTH-1:0];
  assign clamped = int'(cand) > F_MAX ? WIDTH'(F_MAX) : int'(cand) < F_MIN ? WIDTH'(F_MIN) : cand;
`ifdef RFG_NO_REPEAT_EN
  assign reject = clamped != cand || cand == freq[ch*WIDTH +: WIDTH];
`else
  assign reject = clamped != cand;
`endif
  assign accept = !reject || tries == TW'(MAX_TRIES - 1);
  assign bus.frequency = freq;
  // draw channels into the shadow set, then publish the whole set in one edge
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      tries <= '0;
      shadow <= '0;
      freq <= '0;
      bus.update <= 1'b0;
      bus.busy <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.update <= 1'b0;
      bus.overrun <= bus.sec && state != IDLE;
      case (state)
        IDLE: if (bus.sec) begin
          state <= DRAW;
          ch <= '0;
          tries <= '0;
          bus.busy <= 1'b1;
        end
        DRAW: if (ch == CW'(CHANNELS)) state <= COMMIT;
          else if (accept) begin
            shadow[ch*WIDTH +: WIDTH] <= clamped;
            ch <= ch + CW'(1);
            tries <= '0;
          end else tries <= tries + TW'(1);
        COMMIT: begin
          freq <= shadow;
          bus.update <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
